// File: rtl/sa_job_scheduler.sv
`default_nettype none
// ============================================================================
//  Module   : sa_job_scheduler
//  Purpose  : Runs a batch of systolic-array jobs on top_pd from a single go
//             pulse. For each job it issues a one-cycle start pulse with
//             strided X/W base addresses and handshakes on top_pd busy. After
//             the last job it waits a drain interval, then steps y_index over
//             all N result rows with rd_valid asserted.
//  Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
//  Ports
//    clk          in   clock
//    n_rst        in   asynchronous active-low reset
//    go_i         in   start batch (sampled in IDLE only)
//    num_jobs_i   in   jobs in batch (0 = immediate done pulse)
//    base_x0_i    in   first X base address
//    base_w0_i    in   first W base address
//    stride_x_i   in   X base increment per job (mod 2^AW)
//    stride_w_i   in   W base increment per job (mod 2^AW)
//    sa_busy_i    in   top_pd busy_o
//    sa_start_o   out  top_pd start_i, one-cycle pulse per job
//    sa_base_x_o  out  top_pd base_addr_x
//    sa_base_w_o  out  top_pd base_addr_w
//    y_index_o    out  top_pd y_index
//    rd_valid_o   out  row selected by y_index_o is valid this cycle
//    busy_o       out  batch in progress
//    job_idx_o    out  index of current job
//    done_o       out  one-cycle pulse at batch end
//    err_o        out  sticky watchdog error
//  Configuration
//    SA_SCHED_WATCHDOG_EN : when defined, a TIMEOUT_CYCLES watchdog guards
//    WAIT_ACK and WAIT_DONE; on expiry err_o is set and the batch ends
//    without drain/readout. When undefined err_o stays 0 and the scheduler
//    waits on top_pd indefinitely.
// ============================================================================
module sa_job_scheduler #(
    parameter int N              = 4,
    parameter int AW             = 6,
    parameter int JW             = 8,
    parameter int DRAIN_CYCLES   = 24,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic                 clk,
    input  logic                 n_rst,
    input  logic                 go_i,
    input  logic [JW-1:0]        num_jobs_i,
    input  logic [AW-1:0]        base_x0_i,
    input  logic [AW-1:0]        base_w0_i,
    input  logic [AW-1:0]        stride_x_i,
    input  logic [AW-1:0]        stride_w_i,
    input  logic                 sa_busy_i,
    output logic                 sa_start_o,
    output logic [AW-1:0]        sa_base_x_o,
    output logic [AW-1:0]        sa_base_w_o,
    output logic [$clog2(N)-1:0] y_index_o,
    output logic                 rd_valid_o,
    output logic                 busy_o,
    output logic [JW-1:0]        job_idx_o,
    output logic                 done_o,
    output logic                 err_o
);

    localparam int c_YW = $clog2(N);
    localparam int c_DW = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;
    localparam int c_TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

    localparam logic [c_YW-1:0] c_Y_LAST     = c_YW'(N - 1);
    localparam logic [c_DW-1:0] c_DRAIN_LAST =
        c_DW'((DRAIN_CYCLES > 0) ? (DRAIN_CYCLES - 1) : 0);
    localparam logic [c_TW-1:0] c_WD_LAST    =
        c_TW'((TIMEOUT_CYCLES > 0) ? (TIMEOUT_CYCLES - 1) : 0);

`ifdef SA_SCHED_WATCHDOG_EN
    localparam bit c_WD_EN = 1'b1;
`else
    // Watchdog compiled out: the expiry term below is constant 0, so the
    // counter and r_err are pruned and err_o is effectively tied low.
    localparam bit c_WD_EN = 1'b0;
`endif

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_ISSUE     = 3'd1,
        S_WAIT_ACK  = 3'd2,
        S_WAIT_DONE = 3'd3,
        S_DRAIN     = 3'd4,
        S_READOUT   = 3'd5,
        S_DONE      = 3'd6
    } t_state;

    t_state          r_state;
    logic [JW-1:0]   r_num_jobs;
    logic [AW-1:0]   r_stride_x;
    logic [AW-1:0]   r_stride_w;
    logic [AW-1:0]   r_base_x;
    logic [AW-1:0]   r_base_w;
    logic [JW-1:0]   r_job_idx;
    logic [c_DW-1:0] r_drain_cnt;
    logic [c_TW-1:0] r_wd_cnt;
    logic [c_YW-1:0] r_y_index;
    logic            r_rd_valid;
    logic            r_start;
    logic            r_done;
    logic            r_busy;
    logic            r_err;

    logic            w_wd_expired;
    logic            w_last_job;

    assign w_wd_expired = c_WD_EN && (r_wd_cnt == c_WD_LAST);
    assign w_last_job   = (JW'(r_job_idx + 1'b1) == r_num_jobs);

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            r_state     <= S_IDLE;
            r_num_jobs  <= '0;
            r_stride_x  <= '0;
            r_stride_w  <= '0;
            r_base_x    <= '0;
            r_base_w    <= '0;
            r_job_idx   <= '0;
            r_drain_cnt <= '0;
            r_wd_cnt    <= '0;
            r_y_index   <= '0;
            r_rd_valid  <= 1'b0;
            r_start     <= 1'b0;
            r_done      <= 1'b0;
            r_busy      <= 1'b0;
            r_err       <= 1'b0;
        end else begin
            // Pulse outputs default low; states below raise them for one cycle.
            r_start <= 1'b0;
            r_done  <= 1'b0;

            case (r_state)
                S_IDLE: begin
                    if (go_i) begin
                        r_err <= 1'b0;
                        if (num_jobs_i != '0) begin
                            r_num_jobs <= num_jobs_i;
                            r_stride_x <= stride_x_i;
                            r_stride_w <= stride_w_i;
                            r_base_x   <= base_x0_i;
                            r_base_w   <= base_w0_i;
                            r_job_idx  <= '0;
                            r_busy     <= 1'b1;
                            r_state    <= S_ISSUE;
                        end else begin
                            // Empty batch: acknowledge without leaving IDLE.
                            r_done <= 1'b1;
                        end
                    end
                end

                S_ISSUE: begin
                    if (!sa_busy_i) begin
                        r_start  <= 1'b1;
                        r_wd_cnt <= '0;
                        r_state  <= S_WAIT_ACK;
                    end
                end

                S_WAIT_ACK: begin
                    // top_pd needs a cycle to raise busy after start; wait for it.
                    if (sa_busy_i) begin
                        r_wd_cnt <= '0;
                        r_state  <= S_WAIT_DONE;
                    end else if (w_wd_expired) begin
                        r_err   <= 1'b1;
                        r_done  <= 1'b1;
                        r_state <= S_DONE;
                    end else begin
                        r_wd_cnt <= r_wd_cnt + 1'b1;
                    end
                end

                S_WAIT_DONE: begin
                    if (!sa_busy_i) begin
                        r_wd_cnt <= '0;
                        if (w_last_job) begin
                            if (DRAIN_CYCLES == 0) begin
                                r_y_index  <= '0;
                                r_rd_valid <= 1'b1;
                                r_state    <= S_READOUT;
                            end else begin
                                r_drain_cnt <= '0;
                                r_state     <= S_DRAIN;
                            end
                        end else begin
                            // Bases only move here, so they hold steady for
                            // the whole issue/ack/done window of each job.
                            r_job_idx <= r_job_idx + 1'b1;
                            r_base_x  <= r_base_x + r_stride_x;
                            r_base_w  <= r_base_w + r_stride_w;
                            r_state   <= S_ISSUE;
                        end
                    end else if (w_wd_expired) begin
                        r_err   <= 1'b1;
                        r_done  <= 1'b1;
                        r_state <= S_DONE;
                    end else begin
                        r_wd_cnt <= r_wd_cnt + 1'b1;
                    end
                end

                S_DRAIN: begin
                    if (r_drain_cnt == c_DRAIN_LAST) begin
                        // Valid/index are set on entry so row 0 is presented
                        // in the very first READOUT cycle.
                        r_y_index  <= '0;
                        r_rd_valid <= 1'b1;
                        r_state    <= S_READOUT;
                    end else begin
                        r_drain_cnt <= r_drain_cnt + 1'b1;
                    end
                end

                S_READOUT: begin
                    if (r_y_index == c_Y_LAST) begin
                        r_y_index  <= '0;
                        r_rd_valid <= 1'b0;
                        r_done     <= 1'b1;
                        r_state    <= S_DONE;
                    end else begin
                        r_y_index <= r_y_index + 1'b1;
                    end
                end

                S_DONE: begin
                    r_y_index  <= '0;
                    r_rd_valid <= 1'b0;
                    r_busy     <= 1'b0;
                    r_state    <= S_IDLE;
                end

                default: begin
                    r_y_index  <= '0;
                    r_rd_valid <= 1'b0;
                    r_busy     <= 1'b0;
                    r_state    <= S_IDLE;
                end
            endcase
        end
    end

    assign sa_start_o  = r_start;
    assign sa_base_x_o = r_base_x;
    assign sa_base_w_o = r_base_w;
    assign y_index_o   = r_y_index;
    assign rd_valid_o  = r_rd_valid;
    assign busy_o      = r_busy;
    assign job_idx_o   = r_job_idx;
    assign done_o      = r_done;
    assign err_o       = r_err;

endmodule
`default_nettype wire

// File: tb/tb_sa_job_scheduler.sv
`default_nettype none
// ============================================================================
//  Module   : tb_sa_job_scheduler
//  Purpose  : Directed self-checking bench for sa_job_scheduler (default
//             build, N=4, AW=6, JW=8, DRAIN_CYCLES=24). A small top_pd stand-in
//             raises busy for 10 cycles after each start pulse.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_sa_job_scheduler;

    logic       clk;
    logic       n_rst;
    logic       go_i;
    logic [7:0] num_jobs_i;
    logic [5:0] base_x0_i;
    logic [5:0] base_w0_i;
    logic [5:0] stride_x_i;
    logic [5:0] stride_w_i;
    logic       sa_busy_i;
    logic       sa_start_o;
    logic [5:0] sa_base_x_o;
    logic [5:0] sa_base_w_o;
    logic [1:0] y_index_o;
    logic       rd_valid_o;
    logic       busy_o;
    logic [7:0] job_idx_o;
    logic       done_o;
    logic       err_o;

    sa_job_scheduler #(
        .N              (4),
        .AW             (6),
        .JW             (8),
        .DRAIN_CYCLES   (24),
        .TIMEOUT_CYCLES (1024)
    ) u_dut (
        .clk         (clk),
        .n_rst       (n_rst),
        .go_i        (go_i),
        .num_jobs_i  (num_jobs_i),
        .base_x0_i   (base_x0_i),
        .base_w0_i   (base_w0_i),
        .stride_x_i  (stride_x_i),
        .stride_w_i  (stride_w_i),
        .sa_busy_i   (sa_busy_i),
        .sa_start_o  (sa_start_o),
        .sa_base_x_o (sa_base_x_o),
        .sa_base_w_o (sa_base_w_o),
        .y_index_o   (y_index_o),
        .rd_valid_o  (rd_valid_o),
        .busy_o      (busy_o),
        .job_idx_o   (job_idx_o),
        .done_o      (done_o),
        .err_o       (err_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // top_pd stand-in: busy for 10 cycles after seeing a start pulse.
    logic [3:0] mock_cnt;
    logic       hold_busy;
    always @(posedge clk or negedge n_rst) begin
        if (!n_rst)              mock_cnt <= 4'd0;
        else if (sa_start_o)     mock_cnt <= 4'd10;
        else if (mock_cnt != 0)  mock_cnt <= mock_cnt - 4'd1;
    end
    assign sa_busy_i = (mock_cnt != 4'd0) | hold_busy;

    // Monitor: logs start pulses, readout rows and done pulses.
    int         cyc = 0;
    int         n_start = 0;
    int         n_done = 0;
    int         t_fall = 0;
    int         t_rv_first = 0;
    int         gap = 0;
    int         rv_run = 0;
    int         rv_to_done = 0;
    logic       prev_busy = 1'b0;
    logic       prev_rv = 1'b0;
    logic [5:0] start_x [64];
    logic [5:0] start_w [64];
    logic [7:0] start_j [64];
    logic [1:0] y_log [8];

    always @(negedge clk) begin
        cyc = cyc + 1;
        if (sa_start_o && n_start < 64) begin
            start_x[n_start] = sa_base_x_o;
            start_w[n_start] = sa_base_w_o;
            start_j[n_start] = job_idx_o;
            n_start = n_start + 1;
        end
        if (prev_busy && !sa_busy_i) t_fall = cyc;
        if (rd_valid_o) begin
            if (!prev_rv) begin
                rv_run     = 0;
                gap        = cyc - t_fall;
                t_rv_first = cyc;
            end
            if (rv_run < 8) y_log[rv_run] = y_index_o;
            rv_run = rv_run + 1;
        end
        if (done_o) begin
            n_done     = n_done + 1;
            rv_to_done = cyc - t_rv_first;
        end
        prev_busy = sa_busy_i;
        prev_rv   = rd_valid_o;
    end

    int n_pass = 0;
    int n_chk  = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk = n_chk + 1;
        assert (obs === exp) n_pass = n_pass + 1;
        else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    endtask

    task automatic wait_done(input string tag, input int limit);
        int i;
        i = 0;
        while (!done_o && i < limit) begin
            @(negedge clk);
            i = i + 1;
        end
        check(tag, 32'(done_o), 32'd1);
    endtask

    task automatic start_batch(input logic [7:0] nj, input logic [5:0] bx, input logic [5:0] bw,
                               input logic [5:0] sx, input logic [5:0] sw);
        num_jobs_i = nj;
        base_x0_i  = bx;
        base_w0_i  = bw;
        stride_x_i = sx;
        stride_w_i = sw;
        go_i       = 1'b1;
        @(negedge clk);
        go_i       = 1'b0;
    endtask

    int s0;
    int d0;
    int ex_x [4] = '{0, 4, 8, 12};
    int ex_w [4] = '{0, 1, 2, 3};

    initial begin
        n_rst      = 1'b0;
        go_i       = 1'b0;
        hold_busy  = 1'b0;
        num_jobs_i = 8'd0;
        base_x0_i  = 6'd0;
        base_w0_i  = 6'd0;
        stride_x_i = 6'd0;
        stride_w_i = 6'd0;
        repeat (3) @(negedge clk);

        // ---- reset state ----
        check("rst_start",  32'(sa_start_o),  32'd0);
        check("rst_busy",   32'(busy_o),      32'd0);
        check("rst_done",   32'(done_o),      32'd0);
        check("rst_rdv",    32'(rd_valid_o),  32'd0);
        check("rst_base_x", 32'(sa_base_x_o), 32'd0);
        check("rst_job",    32'(job_idx_o),   32'd0);
        check("rst_err",    32'(err_o),       32'd0);
        n_rst = 1'b1;
        @(negedge clk);

        // ---- 4-job batch, bases 0/0, strides 4/1 ----
        s0 = n_start;
        d0 = n_done;
        start_batch(8'd4, 6'd0, 6'd0, 6'd4, 6'd1);
        check("t1_lat1_start", 32'(sa_start_o), 32'd0);
        check("t1_lat1_busy",  32'(busy_o),     32'd1);
        @(negedge clk);
        check("t1_lat2_start", 32'(sa_start_o), 32'd1);
        wait_done("t1_done", 600);
        check("t1_done_busy", 32'(busy_o),    32'd1);
        check("t1_done_y",    32'(y_index_o), 32'd0);
        check("t1_done_job",  32'(job_idx_o), 32'd3);
        @(negedge clk);
        check("t1_after_busy", 32'(busy_o), 32'd0);
        check("t1_after_done", 32'(done_o), 32'd0);
        check("t1_nstart", 32'(n_start - s0), 32'd4);
        for (int k = 0; k < 4; k++) begin
            check($sformatf("t1_bx%0d", k), 32'(start_x[s0 + k]), 32'(ex_x[k]));
            check($sformatf("t1_bw%0d", k), 32'(start_w[s0 + k]), 32'(ex_w[k]));
            check($sformatf("t1_y%0d", k),  32'(y_log[k]),       32'(k));
        end
        check("t1_ndone",      32'(n_done - d0), 32'd1);
        check("t1_drain_gap",  32'(gap),         32'd25);
        check("t1_rv_len",     32'(rv_run),      32'd4);
        check("t1_rv_to_done", 32'(rv_to_done),  32'd4);

        // ---- zero-job batch ----
        s0 = n_start;
        d0 = n_done;
        start_batch(8'd0, 6'd0, 6'd0, 6'd0, 6'd0);
        check("t2_done", 32'(done_o), 32'd1);
        check("t2_busy", 32'(busy_o), 32'd0);
        @(negedge clk);
        check("t2_done_clr", 32'(done_o), 32'd0);
        repeat (3) @(negedge clk);
        check("t2_nstart", 32'(n_start - s0), 32'd0);
        check("t2_ndone",  32'(n_done - d0),  32'd1);
        check("t2_busy2",  32'(busy_o),       32'd0);

        // ---- base wrap: 60 + 4 -> 0 ----
        s0 = n_start;
        start_batch(8'd2, 6'd60, 6'd5, 6'd4, 6'd3);
        wait_done("t3_done", 400);
        @(negedge clk);
        check("t3_nstart", 32'(n_start - s0),     32'd2);
        check("t3_bx0",    32'(start_x[s0]),      32'd60);
        check("t3_bx1",    32'(start_x[s0 + 1]),  32'd0);
        check("t3_bw1",    32'(start_w[s0 + 1]),  32'd8);

        // ---- busy held at go, mid-batch go ignored ----
        s0 = n_start;
        d0 = n_done;
        hold_busy = 1'b1;
        start_batch(8'd1, 6'd7, 6'd9, 6'd1, 6'd1);
        repeat (5) @(negedge clk);
        check("t4_withheld", 32'(n_start - s0), 32'd0);
        check("t4_busy",     32'(busy_o),       32'd1);
        start_batch(8'd7, 6'd0, 6'd0, 6'd0, 6'd0);
        hold_busy = 1'b0;
        @(negedge clk);
        check("t4_start", 32'(sa_start_o), 32'd1);
        repeat (4) @(negedge clk);
        start_batch(8'd7, 6'd0, 6'd0, 6'd0, 6'd0);
        wait_done("t4_done", 400);
        check("t4_job", 32'(job_idx_o), 32'd0);
        @(negedge clk);
        check("t4_nstart", 32'(n_start - s0), 32'd1);
        check("t4_bx",     32'(start_x[s0]),  32'd7);
        check("t4_ndone",  32'(n_done - d0),  32'd1);

        // ---- reset during WAIT_DONE of job 2 ----
        start_batch(8'd4, 6'd0, 6'd0, 6'd4, 6'd1);
        for (int i = 0; i < 300 && job_idx_o != 8'd2; i++) @(negedge clk);
        check("t5_reach_job2", 32'(job_idx_o), 32'd2);
        repeat (5) @(negedge clk);
        check("t5_pre_busy", 32'(busy_o), 32'd1);
        d0 = n_done;
        n_rst = 1'b0;
        #1;
        check("t5_rst_busy",  32'(busy_o),      32'd0);
        check("t5_rst_job",   32'(job_idx_o),   32'd0);
        check("t5_rst_bx",    32'(sa_base_x_o), 32'd0);
        check("t5_rst_bw",    32'(sa_base_w_o), 32'd0);
        check("t5_rst_start", 32'(sa_start_o),  32'd0);
        check("t5_rst_done",  32'(done_o),      32'd0);
        repeat (2) @(negedge clk);
        n_rst = 1'b1;
        repeat (3) @(negedge clk);
        check("t5_no_done", 32'(n_done - d0), 32'd0);
        s0 = n_start;
        d0 = n_done;
        start_batch(8'd4, 6'd0, 6'd0, 6'd4, 6'd1);
        wait_done("t5_done", 600);
        @(negedge clk);
        check("t5_nstart", 32'(n_start - s0),    32'd4);
        check("t5_job0",   32'(start_j[s0]),     32'd0);
        check("t5_bx0",    32'(start_x[s0]),     32'd0);
        check("t5_job3",   32'(start_j[s0 + 3]), 32'd3);
        check("t5_bx3",    32'(start_x[s0 + 3]), 32'd12);
        check("t5_bw3",    32'(start_w[s0 + 3]), 32'd3);
        check("t5_ndone",  32'(n_done - d0),     32'd1);
        check("t5_err",    32'(err_o),           32'd0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/sa_job_scheduler.md
Name: sa_job_scheduler

Overview:
Sequences a batch of systolic-array jobs on top_pd without testbench or CPU involvement per job. From one go pulse it issues num_jobs start pulses with strided base_addr_x/base_addr_w and handshakes on top_pd busy_o for each job. It then waits a drain interval and steps y_index across all N result rows, flagging each one as valid. It sits between the host/config logic and top_pd's start_i, base_addr_*, busy_o and y_index ports.

Parameters:
N, 4, array dimension; readout steps y_index 0..N-1.
AW, 6, SPAD address width; base registers and strides are AW bits.
JW, 8, width of job count.
DRAIN_CYCLES, 24, idle cycles between last job completion and readout (0 = skip).
TIMEOUT_CYCLES, 1024, watchdog limit (optional feature only).

Ports:
clk  in  1  clock
n_rst  in  1  asynchronous active-low reset
go_i  in  1  start batch (sampled in IDLE only)
num_jobs_i  in  JW  jobs in batch
base_x0_i  in  AW  first X base address
base_w0_i  in  AW  first W base address
stride_x_i  in  AW  X base increment per job
stride_w_i  in  AW  W base increment per job
sa_busy_i  in  1  top_pd busy_o
sa_start_o  out  1  to top_pd start_i; one-cycle pulse
sa_base_x_o  out  AW  to top_pd base_addr_x
sa_base_w_o  out  AW  to top_pd base_addr_w
y_index_o  out  $clog2(N)  to top_pd y_index
rd_valid_o  out  1  y_out row selected by y_index_o is valid this cycle
busy_o  out  1  batch in progress (state != IDLE)
job_idx_o  out  JW  index of current job
done_o  out  1  one-cycle pulse at batch end
err_o  out  1  watchdog error, sticky (optional feature)

Behaviour:
- Reset (async, n_rst low): state IDLE. All outputs are 0, as are all counters and base registers. Reset is legal in any state; a partially run batch is abandoned with no done_o.
- All outputs are registered.
- IDLE: go_i=1 and num_jobs_i!=0 -> latch num_jobs, strides and bases; job_idx=0; go to ISSUE. go_i=1 and num_jobs_i==0 -> done_o pulse on the next cycle; stay IDLE. go_i is ignored in every other state.
- ISSUE: if sa_busy_i==0 is sampled, sa_start_o is high for exactly the next cycle and state goes to WAIT_ACK. Otherwise stay in ISSUE.
- WAIT_ACK: sa_busy_i==1 -> WAIT_DONE.
- WAIT_DONE: sa_busy_i==0 -> if job_idx+1==num_jobs go to DRAIN. Otherwise job_idx+=1, base_x+=stride_x, base_w+=stride_w, go to ISSUE.
- Base arithmetic is modulo 2^AW (wrap, no saturation).
- sa_base_*_o is stable from entry to ISSUE until leaving WAIT_DONE.
- Latency from go_i sampled to sa_start_o high is 2 cycles when sa_busy_i=0.
- DRAIN: count DRAIN_CYCLES cycles, then go to READOUT. With DRAIN_CYCLES=0, go straight to READOUT.
- READOUT: N consecutive cycles with y_index_o=0,1,..,N-1 and rd_valid_o=1 on each. Then go to DONE.
- DONE: done_o=1 for one cycle, y_index_o returns to 0, go to IDLE. busy_o is low from the cycle after DONE.

Optional Feature:
Macro SA_SCHED_WATCHDOG_EN.
- Defined: a counter runs in WAIT_ACK and in WAIT_DONE, reset on each state entry. Reaching TIMEOUT_CYCLES sets err_o and moves to DONE, skipping DRAIN/READOUT; done_o still pulses.
  - err_o clears only on reset or the next accepted go_i.
- Undefined: err_o is tied 0 and the block waits indefinitely.

Test Plan:
- N=4, num_jobs=4, base 0/0, strides 4/1, mock top_pd busy for 10 cycles per start -> exactly 4 sa_start_o pulses with bases (0,0),(4,1),(8,2),(12,3). Then 24 drain cycles, y_index_o 0..3 with rd_valid_o, then one done_o. With real top_pd, X=1..16 and W=identity, Y equals X.
- go_i with num_jobs_i=0 -> no sa_start_o, done_o high 1 cycle after go, busy_o stays 0.
- base_x0=60, stride_x=4, num_jobs=2 -> sa_base_x_o = 60 then 0 (wrap).
- sa_busy_i held high at go -> sa_start_o withheld until sa_busy_i falls, then exactly one pulse. go_i pulsed again mid-batch -> ignored, job count unchanged.
- n_rst asserted while in WAIT_DONE of job 2 -> all outputs 0 immediately, no done_o. A new go runs a full batch from job 0.
- SA_SCHED_WATCHDOG_EN, TIMEOUT_CYCLES=16, sa_busy_i never rises -> err_o set 16 cycles after entering WAIT_ACK, done_o pulses, no rd_valid_o. The next go clears err_o.
